sq_dist_accum: RTL

Streaming squared-Euclidean-distance accumulator for the KNN datapath. Accepts one feature pair (query, reference) per cycle and accumulates the sum of the squared differences over `DIMS` beats. It then presents the distance on a valid/ready output that feeds the square-root stage directly. A separate result register lets the next vector accumulate while the previous distance waits downstream.

---
 rtl/sq_dist_accum.sv | 101 ++++++++++
 1 files changed

// File: rtl/sq_dist_accum.sv
// Streaming squared-Euclidean-distance accumulator with a one-deep valid/ready result slot.
// Define SQ_DIST_SIGNED_EN to treat a_i/b_i as two's-complement signed operands.
module sq_dist_accum #(
    parameter int unsigned  DATA_WIDTH = 8,
    parameter int unsigned  DIMS       = 4,
    localparam int unsigned ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(DIMS)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [ACC_WIDTH-1:0]  dist_o
);

    localparam int unsigned CntWidth = $clog2(DIMS);
    localparam int unsigned SqWidth  = 2 * DATA_WIDTH + 2;
    localparam logic [CntWidth-1:0] LastCnt = CntWidth'(DIMS - 1);

    typedef enum logic {StEmpty, StFull} slot_e;

    slot_e                 slot_q, slot_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [ACC_WIDTH-1:0]  res_q, res_d;

    logic [DATA_WIDTH:0]   a_ext, b_ext, diff, mag;
    logic [SqWidth-1:0]    mag_w, sq_full;
    logic [ACC_WIDTH-1:0]  sum;
    logic                  last_beat, accept, final_accept;

    // One extra bit keeps the difference exact in both operand modes.
`ifdef SQ_DIST_SIGNED_EN
    assign a_ext = {a_i[DATA_WIDTH-1], a_i};
    assign b_ext = {b_i[DATA_WIDTH-1], b_i};
`else
    assign a_ext = {1'b0, a_i};
    assign b_ext = {1'b0, b_i};
`endif

    assign diff    = a_ext - b_ext;
    assign mag     = diff[DATA_WIDTH] ? -diff : diff;
    assign mag_w   = {{(DATA_WIDTH + 1){1'b0}}, mag};
    assign sq_full = mag_w * mag_w;
    assign sum     = acc_q + ACC_WIDTH'(sq_full);

    assign last_beat    = (cnt_q == LastCnt);
    assign ready_o      = ~(last_beat & (slot_q == StFull) & ~ready_i);
    assign accept       = valid_i & ready_o;
    assign final_accept = accept & last_beat;

    assign valid_o = (slot_q == StFull);
    assign dist_o  = res_q;

    always_comb begin
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        res_d  = res_q;
        slot_d = slot_q;

        if (accept) begin
            if (last_beat) begin
                cnt_d = '0;
                acc_d = '0;
                res_d = sum;
            end else begin
                cnt_d = cnt_q + CntWidth'(1);
                acc_d = sum;
            end
        end

        unique case (slot_q)
            StEmpty: begin
                if (final_accept) slot_d = StFull;
            end
            StFull: begin
                // A consume coinciding with a final beat reloads the slot instead of emptying it.
                if (!final_accept && ready_i) slot_d = StEmpty;
            end
            default: slot_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slot_q <= StEmpty;
            cnt_q  <= '0;
            acc_q  <= '0;
            res_q  <= '0;
        end else begin
            slot_q <= slot_d;
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            res_q  <= res_d;
        end
    end

endmodule
